// File: rtl/rggen_register_access_arbiter.sv
// Round-robin arbiter sharing one register-block access port among HOSTS hosts.
// Optional downstream watchdog: define RGGEN_REGISTER_ARBITER_TIMEOUT_EN.
module rggen_register_access_arbiter #(
    parameter int HOSTS          = 2,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [HOSTS-1:0]               i_request_valid,
    output logic [HOSTS-1:0]               o_request_ready,
    input  logic [HOSTS-1:0]               i_request_write,
    input  logic [HOSTS*ADDRESS_WIDTH-1:0] i_request_address,
    input  logic [HOSTS*BUS_WIDTH-1:0]     i_request_data,
    input  logic [HOSTS*BUS_WIDTH/8-1:0]   i_request_strobe,
    output logic [HOSTS-1:0]               o_response_valid,
    input  logic [HOSTS-1:0]               i_response_ready,
    output logic [1:0]                     o_response_status,
    output logic [BUS_WIDTH-1:0]           o_response_data,
    output logic                           o_access_valid,
    output logic                           o_access_write,
    output logic [ADDRESS_WIDTH-1:0]       o_access_address,
    output logic [BUS_WIDTH-1:0]           o_access_data,
    output logic [BUS_WIDTH/8-1:0]         o_access_strobe,
    input  logic                           i_access_ready,
    input  logic [1:0]                     i_access_status,
    input  logic [BUS_WIDTH-1:0]           i_access_data
);
    localparam int SW = BUS_WIDTH / 8;
    localparam int GW = (HOSTS > 1) ? $clog2(HOSTS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_e;

    state_e                   state_q;
    logic [GW-1:0]            grant_q;
    logic                     write_q;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic [BUS_WIDTH-1:0]     data_q;
    logic [SW-1:0]            strobe_q;
    logic [1:0]               status_q;
    logic [BUS_WIDTH-1:0]     rdata_q;
    logic                     access_valid_q;
    logic [HOSTS-1:0]         response_valid_q;

    logic                     win_valid;
    logic [GW-1:0]            win_idx;
    logic [HOSTS-1:0]         win_onehot;
    logic                     expired;

    function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] last,
                                               input int offset);
        return GW'((int'(last) + 1 + offset) % HOSTS);
    endfunction

    // grant_q doubles as the last-granted host that seeds the search
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < HOSTS; i++) begin
            if (!win_valid && i_request_valid[rr_index(grant_q, i)]) begin
                win_valid = 1'b1;
                win_idx   = rr_index(grant_q, i);
            end
        end
    end

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = win_valid;
    end

    assign o_request_ready = (state_q == IDLE) ? win_onehot : '0;

`ifdef RGGEN_REGISTER_ARBITER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] timer_q;
    assign expired = (timer_q == TW'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog in this build: ACCESS waits for the downstream forever
    assign expired = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q          <= IDLE;
            grant_q          <= GW'(HOSTS - 1);
            write_q          <= 1'b0;
            address_q        <= '0;
            data_q           <= '0;
            strobe_q         <= '0;
            status_q         <= '0;
            rdata_q          <= '0;
            access_valid_q   <= 1'b0;
            response_valid_q <= '0;
`ifdef RGGEN_REGISTER_ARBITER_TIMEOUT_EN
            timer_q          <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        grant_q        <= win_idx;
                        write_q        <= i_request_write[win_idx];
                        address_q      <= i_request_address[int'(win_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        data_q         <= i_request_data[int'(win_idx)*BUS_WIDTH +: BUS_WIDTH];
                        strobe_q       <= i_request_strobe[int'(win_idx)*SW +: SW];
                        access_valid_q <= 1'b1;
                        state_q        <= ACCESS;
`ifdef RGGEN_REGISTER_ARBITER_TIMEOUT_EN
                        timer_q        <= '0;
`endif
                    end
                end
                ACCESS: begin
                    if (i_access_ready) begin
                        status_q                  <= i_access_status;
                        rdata_q                   <= write_q ? '0 : i_access_data;
                        access_valid_q            <= 1'b0;
                        response_valid_q[grant_q] <= 1'b1;
                        state_q                   <= RESPOND;
                    end else if (expired) begin
                        status_q                  <= 2'b10;
                        rdata_q                   <= '0;
                        access_valid_q            <= 1'b0;
                        response_valid_q[grant_q] <= 1'b1;
                        state_q                   <= RESPOND;
                    end
`ifdef RGGEN_REGISTER_ARBITER_TIMEOUT_EN
                    else begin
                        timer_q <= timer_q + 1'b1;
                    end
`endif
                end
                RESPOND: begin
                    if (i_response_ready[grant_q]) begin
                        response_valid_q <= '0;
                        state_q          <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_response_valid  = response_valid_q;
    assign o_response_status = status_q;
    assign o_response_data   = rdata_q;
    assign o_access_valid    = access_valid_q;
    assign o_access_write    = write_q;
    assign o_access_address  = address_q;
    assign o_access_data     = data_q;
    assign o_access_strobe   = strobe_q;

endmodule

// File: tb/tb_rggen_register_access_arbiter.sv
// Bench for rggen_register_access_arbiter: directed vectors, corner sequences,
// and randomized traffic against a transaction-level round-robin model.
module tb_rggen_register_access_arbiter;
    localparam int H  = 2;
    localparam int AW = 8;
    localparam int BW = 32;
    localparam int SW = BW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [H-1:0]    req_valid, req_ready, req_write;
    logic [H*AW-1:0] req_addr;
    logic [H*BW-1:0] req_data;
    logic [H*SW-1:0] req_strb;
    logic [H-1:0]    resp_valid, resp_ready;
    logic [1:0]      resp_status;
    logic [BW-1:0]   resp_data;
    logic            acc_valid, acc_write, acc_ready;
    logic [AW-1:0]   acc_addr;
    logic [BW-1:0]   acc_data, acc_rdata;
    logic [SW-1:0]   acc_strb;
    logic [1:0]      acc_status;

    rggen_register_access_arbiter #(
        .HOSTS(H), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_request_valid(req_valid), .o_request_ready(req_ready),
        .i_request_write(req_write), .i_request_address(req_addr),
        .i_request_data(req_data), .i_request_strobe(req_strb),
        .o_response_valid(resp_valid), .i_response_ready(resp_ready),
        .o_response_status(resp_status), .o_response_data(resp_data),
        .o_access_valid(acc_valid), .o_access_write(acc_write),
        .o_access_address(acc_addr), .o_access_data(acc_data),
        .o_access_strobe(acc_strb), .i_access_ready(acc_ready),
        .i_access_status(acc_status), .i_access_data(acc_rdata)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Model: pending request per host plus the round-robin pointer
    bit            pend[H];
    logic          pw[H];
    logic [AW-1:0] pa[H];
    logic [BW-1:0] pd[H];
    logic [SW-1:0] ps[H];
    int            last_g;

    typedef struct {
        int            host;
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
        logic [SW-1:0] strb;
        int            dly;
        logic [1:0]    st;
        logic [BW-1:0] rd;
        int            hold;
        int            exp_grant;
        logic [BW-1:0] exp_data;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick();
        for (int i = 1; i <= H; i++) begin
            if (pend[(last_g + i) % H]) return (last_g + i) % H;
        end
        return -1;
    endfunction

    task automatic set_req(input int h, input logic wr, input logic [AW-1:0] a,
                           input logic [BW-1:0] d, input logic [SW-1:0] s);
        pend[h] = 1'b1;
        pw[h]   = wr;
        pa[h]   = a;
        pd[h]   = d;
        ps[h]   = s;
    endtask

    task automatic drive_reqs();
        for (int h = 0; h < H; h++) begin
            req_valid[h]            = pend[h];
            req_write[h]            = pw[h];
            req_addr[h*AW +: AW]    = pa[h];
            req_data[h*BW +: BW]    = pd[h];
            req_strb[h*SW +: SW]    = ps[h];
        end
    endtask

    task automatic model_reset();
        last_g = H - 1;
        for (int h = 0; h < H; h++) begin
            pend[h] = 1'b0;
            pw[h]   = 1'b0;
            pa[h]   = '0;
            pd[h]   = '0;
            ps[h]   = '0;
        end
    endtask

    // One full transaction for host w, which must be the expected winner
    task automatic serve(input int w, input logic [BW-1:0] exp_d, input int dly,
                         input logic [1:0] st, input logic [BW-1:0] rd, input int hold);
        logic [H-1:0] oh;
        oh    = '0;
        oh[w] = 1'b1;
        drive_reqs();
        #1;
        chk("req_ready_grant", 64'(req_ready), 64'(oh));
        tick();
        last_g  = w;
        pend[w] = 1'b0;
        req_valid[w]         = 1'b0;
        req_write[w]         = ~pw[w];
        req_addr[w*AW +: AW] = ~pa[w];
        req_data[w*BW +: BW] = ~pd[w];
        req_strb[w*SW +: SW] = ~ps[w];
        #1;
        chk("acc_valid", 64'(acc_valid), 64'(1));
        chk("acc_write", 64'(acc_write), 64'(pw[w]));
        chk("acc_addr", 64'(acc_addr), 64'(pa[w]));
        chk("acc_data", 64'(acc_data), 64'(pd[w]));
        chk("acc_strb", 64'(acc_strb), 64'(ps[w]));
        for (int k = 0; k < dly; k++) begin
            resp_ready = H'($urandom);
            tick();
            chk("acc_wait_valid", 64'(acc_valid), 64'(1));
            chk("acc_wait_no_grant", 64'(req_ready), 64'(0));
            chk("acc_wait_no_resp", 64'(resp_valid), 64'(0));
        end
        resp_ready = '0;
        acc_ready  = 1'b1;
        acc_status = st;
        acc_rdata  = rd;
        tick();
        acc_ready  = 1'b0;
        acc_status = 2'(~st);
        acc_rdata  = $urandom;
        chk("acc_done_valid", 64'(acc_valid), 64'(0));
        chk("resp_valid", 64'(resp_valid), 64'(oh));
        chk("resp_data", 64'(resp_data), 64'(exp_d));
        chk("resp_status", 64'(resp_status), 64'(st));
        for (int k = 0; k < hold; k++) begin
            resp_ready = ~oh;
            acc_ready  = 1'b1;
            tick();
            chk("hold_resp_valid", 64'(resp_valid), 64'(oh));
            chk("hold_resp_data", 64'(resp_data), 64'(exp_d));
            chk("hold_no_grant", 64'(req_ready), 64'(0));
        end
        acc_ready  = 1'b0;
        resp_ready = oh;
        tick();
        resp_ready = '0;
        chk("resp_released", 64'(resp_valid), 64'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
        chk({tag, "_resp_status"}, 64'(resp_status), 64'(0));
        chk({tag, "_resp_data"}, 64'(resp_data), 64'(0));
        chk({tag, "_acc_valid"}, 64'(acc_valid), 64'(0));
        chk({tag, "_acc_write"}, 64'(acc_write), 64'(0));
        chk({tag, "_acc_addr"}, 64'(acc_addr), 64'(0));
        chk({tag, "_acc_data"}, 64'(acc_data), 64'(0));
        chk({tag, "_acc_strb"}, 64'(acc_strb), 64'(0));
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_data   = '0;
        req_strb   = '0;
        resp_ready = '0;
        acc_ready  = 1'b0;
        acc_status = '0;
        acc_rdata  = '0;
        model_reset();

        vecs[0] = '{0, 1'b0, 8'h10, 32'h0, 4'h0, 2, 2'b00, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF};
        vecs[1] = '{1, 1'b1, 8'h20, 32'h12345678, 4'hF, 0, 2'b10, 32'hAAAA5555, 0, 1, 32'h0};
        vecs[2] = '{0, 1'b0, 8'h3C, 32'h0, 4'h0, 7, 2'b11, 32'h0BADF00D, 1, 0, 32'h0BADF00D};
        vecs[3] = '{1, 1'b1, 8'hFF, 32'hFFFFFFFF, 4'h5, 1, 2'b00, 32'h11111111, 0, 1, 32'h0};

        tick();
        tick();
        rst = 1'b0;
        chk_all_zero("reset");

        // Simultaneous requests twice: grants 0,1,0,1
        set_req(0, 1'b0, 8'h04, 32'h0, 4'h0);
        set_req(1, 1'b1, 8'h08, 32'hCAFEF00D, 4'h3);
        serve(0, 32'h00000001, 1, 2'b00, 32'h00000001, 0);
        serve(1, 32'h0, 0, 2'b00, 32'h00000002, 0);
        set_req(0, 1'b1, 8'h0C, 32'h55AA55AA, 4'hC);
        set_req(1, 1'b0, 8'h40, 32'h0, 4'h0);
        serve(0, 32'h0, 0, 2'b10, 32'h00000003, 0);
        serve(1, 32'h00000004, 2, 2'b11, 32'h00000004, 0);

        foreach (vecs[i]) begin
            set_req(vecs[i].host, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb);
            serve(vecs[i].exp_grant, vecs[i].exp_data, vecs[i].dly,
                  vecs[i].st, vecs[i].rd, vecs[i].hold);
        end

        // Response held off 5 cycles while the other host waits
        set_req(0, 1'b0, 8'h50, 32'h0, 4'h0);
        set_req(1, 1'b0, 8'h54, 32'h0, 4'h0);
        serve(0, 32'h87654321, 1, 2'b00, 32'h87654321, 5);
        serve(1, 32'h0F0F0F0F, 0, 2'b00, 32'h0F0F0F0F, 0);

        // Reset during ACCESS drops the access; host 0 wins next
        set_req(1, 1'b1, 8'h77, 32'h13572468, 4'hA);
        drive_reqs();
        tick();
        chk("pre_reset_acc_valid", 64'(acc_valid), 64'(1));
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        model_reset();
        drive_reqs();
        chk_all_zero("midreset");
        set_req(0, 1'b0, 8'h11, 32'h0, 4'h0);
        set_req(1, 1'b0, 8'h22, 32'h0, 4'h0);
        serve(0, 32'h01020304, 0, 2'b00, 32'h01020304, 0);
        serve(1, 32'h05060708, 0, 2'b00, 32'h05060708, 0);

`ifdef RGGEN_REGISTER_ARBITER_TIMEOUT_EN
        begin
            int n;
            logic [H-1:0] oh;
            set_req(0, 1'b0, 8'h99, 32'h0, 4'h0);
            oh = '0;
            oh[0] = 1'b1;
            drive_reqs();
            acc_rdata = 32'hFFFFFFFF;
            tick();
            last_g = 0;
            pend[0] = 1'b0;
            req_valid = '0;
            n = 0;
            for (int k = 0; k < 20; k++) begin
                if (!acc_valid) break;
                n++;
                tick();
            end
            chk("timeout_cycles", 64'(n), 64'(8));
            chk("timeout_resp_valid", 64'(resp_valid), 64'(oh));
            chk("timeout_status", 64'(resp_status), 64'(2'b10));
            chk("timeout_data", 64'(resp_data), 64'(0));
            resp_ready = oh;
            tick();
            resp_ready = '0;
            chk("timeout_released", 64'(resp_valid), 64'(0));
        end
`endif

        // Randomized traffic against the round-robin model
        for (int t = 0; t < 40; t++) begin
            int w;
            logic [1:0] st;
            logic [BW-1:0] rd;
            for (int h = 0; h < H; h++) begin
                if (!pend[h] && $urandom_range(0, 1) == 1)
                    set_req(h, 1'($urandom), AW'($urandom), $urandom, SW'($urandom));
            end
            if (rr_pick() < 0) begin
                set_req($urandom_range(0, H-1), 1'($urandom), AW'($urandom),
                        $urandom, SW'($urandom));
            end
            w = rr_pick();
            case ($urandom_range(0, 2))
                0:       st = 2'b00;
                1:       st = 2'b10;
                default: st = 2'b11;
            endcase
            rd = $urandom;
            serve(w, pw[w] ? '0 : rd, $urandom_range(0, 3), st, rd, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
